// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-stream instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned LANE_W         = 2;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    BYTE,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian stream bytes into one instruction word.
// Lane counter and word_full flag clear when the word is written out.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift_en,
  input  logic                        clear,
  input  logic [7:0]                  byte_data,
  output logic                        last_lane_c,
  output logic [8*BYTES_PER_WORD-1:0] word_c
);

  localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;

  logic [LANE_W-1:0] lane;
  logic [WORD_W-1:0] data;
  logic              word_full;

  // Shift accepted bytes into their lane; hold off once the word is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane      <= '0;
      data      <= '0;
      word_full <= 1'b0;
    end else if (clear) begin
      lane      <= '0;
      word_full <= 1'b0;
    end else if (shift_en && !word_full) begin
      data[8*lane +: 8] <= byte_data;
      lane              <= lane + LANE_W'(1);
      if (lane == LANE_W'(BYTES_PER_WORD - 1)) begin
        word_full <= 1'b1;
      end
    end
  end

  // Word as it will look once the byte on the input is taken.
  always_comb begin
    word_c            = data;
    word_c[8*lane +: 8] = byte_data;
  end

  assign last_lane_c = (lane == LANE_W'(BYTES_PER_WORD - 1)) && !word_full;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: header N, then N little-endian words written
// to consecutive imem addresses; the core stays in reset until the load ends.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned AddressWidth = 10,
  parameter int unsigned DataWidth    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    byte_valid_i,
  input  logic [7:0]              byte_data_i,
  output logic                    byte_ready_o,
  output logic                    imem_ld_o,
  output logic [AddressWidth-1:0] imem_ld_addr_o,
  output logic [DataWidth-1:0]    imem_ld_data_o,
  output logic                    core_rst_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned IDX_W    = AddressWidth + 1;
  localparam int unsigned HDR_W    = 8 * HDR_BYTES;
  localparam int unsigned CAPACITY = 1 << AddressWidth;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_IMAGE = CSUM;
`else
  localparam state_t AFTER_IMAGE = DONE;
`endif

  state_t               state;
  state_t               state_next;
  logic                 accept_c;
  logic [HDR_W-1:0]     n_words;
  logic [HDR_W-1:0]     hdr_n_c;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_inc_c;
  logic                 last_word_c;
  logic                 last_lane_c;
  logic [DataWidth-1:0] word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  // Stream handshake is a pure function of state.
  assign byte_ready_o = (state == HDR_LO) || (state == HDR_HI) ||
                        (state == BYTE)   || (state == CSUM);
  assign accept_c     = byte_valid_i && byte_ready_o;
  assign hdr_n_c      = {byte_data_i, n_words[7:0]};
  assign idx_inc_c    = idx + IDX_W'(1);
  assign last_word_c  = (32'(idx_inc_c) == 32'(n_words));

  // Byte lanes of the word under assembly.
  word_assembler u_word_assembler (
    .clk         (clk_i),
    .rst         (rst_i),
    .shift_en    (accept_c && (state == BYTE)),
    .clear       (state == WRITE),
    .byte_data   (byte_data_i),
    .last_lane_c (last_lane_c),
    .word_c      (word_c)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= HDR_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      HDR_LO: if (accept_c) state_next = HDR_HI;
      HDR_HI: begin
        if (accept_c) begin
          if (32'(hdr_n_c) > CAPACITY) begin
            state_next = ERR;
          end else if (hdr_n_c == '0) begin
            state_next = AFTER_IMAGE;
          end else begin
            state_next = BYTE;
          end
        end
      end
      BYTE:   if (accept_c && last_lane_c) state_next = WRITE;
      WRITE:  state_next = last_word_c ? AFTER_IMAGE : BYTE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM:   if (accept_c) state_next = (byte_data_i == csum) ? DONE : ERR;
`endif
      DONE:   state_next = DONE;
      ERR:    state_next = ERR;
      default: state_next = HDR_LO;
    endcase
  end

  // Registered outputs, header length and word index.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      imem_ld_o      <= 1'b0;
      imem_ld_addr_o <= '0;
      imem_ld_data_o <= '0;
      core_rst_o     <= 1'b1;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      n_words        <= '0;
      idx            <= '0;
    end else begin
      imem_ld_o  <= (state_next == WRITE);
      core_rst_o <= (state_next != DONE);
      done_o     <= (state_next == DONE);
      err_o      <= (state_next == ERR);
      if (accept_c && (state == HDR_LO)) n_words[7:0]  <= byte_data_i;
      if (accept_c && (state == HDR_HI)) n_words[15:8] <= byte_data_i;
      if (accept_c && (state == BYTE) && last_lane_c) begin
        imem_ld_addr_o <= idx[AddressWidth-1:0];
        imem_ld_data_o <= word_c;
      end
      if (state == WRITE) idx <= idx_inc_c;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over header and data bytes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum <= '0;
    end else if (accept_c && ((state == HDR_LO) || (state == HDR_HI) || (state == BYTE))) begin
      csum <= csum ^ byte_data_i;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (either IMEM_LOADER_CHECKSUM_EN build).
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int unsigned AW = 10;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          byte_valid_i = 1'b0;
  logic [7:0]    byte_data_i = 8'h00;
  logic          byte_ready_o;
  logic          imem_ld_o;
  logic [AW-1:0] imem_ld_addr_o;
  logic [31:0]   imem_ld_data_o;
  logic          core_rst_o;
  logic          done_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]    frame [0:10];
  logic [AW-1:0] wr_addr [0:63];
  logic [31:0]   wr_data [0:63];
  int            wr_count = 0;
  int            base;

  imem_loader #(.AddressWidth(AW), .DataWidth(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .byte_valid_i   (byte_valid_i),
    .byte_data_i    (byte_data_i),
    .byte_ready_o   (byte_ready_o),
    .imem_ld_o      (imem_ld_o),
    .imem_ld_addr_o (imem_ld_addr_o),
    .imem_ld_data_o (imem_ld_data_o),
    .core_rst_o     (core_rst_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Record every write strobe; the loader must not take bytes during it.
  always @(negedge clk_i) begin
    if (imem_ld_o) begin
      if (wr_count < 64) begin
        wr_addr[wr_count] = imem_ld_addr_o;
        wr_data[wr_count] = imem_ld_data_o;
      end
      wr_count++;
      check("ready_in_write", 32'(byte_ready_o), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk_i);
    @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    t = 0;
    while (!byte_ready_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    if (!byte_ready_o) begin
      check("accept_timeout", 32'(b), 32'hFFFF_FFFF);
    end else begin
      @(posedge clk_i);
    end
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < FRAME_LEN; i++) begin
      send_byte(frame[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    repeat (3) @(negedge clk_i);
  endtask

  task automatic check_two_words(input string tag);
    check({tag, "_count"}, 32'(wr_count - base), 32'd2);
    check({tag, "_addr0"}, 32'(wr_addr[base]),   32'd0);
    check({tag, "_data0"}, wr_data[base],        32'h0010_0513);
    check({tag, "_addr1"}, 32'(wr_addr[base+1]), 32'd1);
    check({tag, "_data1"}, wr_data[base+1],      32'h0010_0073);
    check({tag, "_done"},  32'(done_o),          32'd1);
    check({tag, "_crst"},  32'(core_rst_o),      32'd0);
    check({tag, "_err"},   32'(err_o),           32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    frame[0] = 8'h02; frame[1] = 8'h00;
    frame[2] = 8'h13; frame[3] = 8'h05; frame[4] = 8'h10; frame[5] = 8'h00;
    frame[6] = 8'h73; frame[7] = 8'h00; frame[8] = 8'h10; frame[9] = 8'h00;
    frame[10] = 8'h67;

    // Reset values
    do_reset();
    check("rst_ready", 32'(byte_ready_o),  32'd1);
    check("rst_ld",    32'(imem_ld_o),     32'd0);
    check("rst_addr",  32'(imem_ld_addr_o), 32'd0);
    check("rst_data",  imem_ld_data_o,      32'd0);
    check("rst_crst",  32'(core_rst_o),    32'd1);
    check("rst_done",  32'(done_o),        32'd0);
    check("rst_err",   32'(err_o),         32'd0);

    // Two words, with write latency probed after each 4th byte
    base = wr_count;
    for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
    check("lat_ld0",   32'(imem_ld_o),      32'd1);
    check("lat_addr0", 32'(imem_ld_addr_o), 32'd0);
    check("lat_data0", imem_ld_data_o,      32'h0010_0513);
    check("lat_crst0", 32'(core_rst_o),     32'd1);
    for (int i = 6; i < 10; i++) send_byte(frame[i], 0);
    check("lat_ld1",   32'(imem_ld_o),      32'd1);
    check("lat_addr1", 32'(imem_ld_addr_o), 32'd1);
    check("lat_crst1", 32'(core_rst_o),     32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(frame[10], 0);
`endif
    repeat (3) @(negedge clk_i);
    check_two_words("two");
    check("two_held_data", imem_ld_data_o, 32'h0010_0073);

    // Empty image
    do_reset();
    base = wr_count;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    repeat (3) @(negedge clk_i);
    check("empty_writes", 32'(wr_count - base), 32'd0);
    check("empty_done",   32'(done_o),          32'd1);
    check("empty_crst",   32'(core_rst_o),      32'd0);

    // Oversize header N = 1025
    do_reset();
    base = wr_count;
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check("over_err_now", 32'(err_o), 32'd1);
    repeat (3) @(negedge clk_i);
    check("over_err",    32'(err_o),           32'd1);
    check("over_crst",   32'(core_rst_o),      32'd1);
    check("over_ready",  32'(byte_ready_o),    32'd0);
    check("over_done",   32'(done_o),          32'd0);
    check("over_writes", 32'(wr_count - base), 32'd0);

    // Maximum legal N = 1024 is accepted into the data phase
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    check("max_err",   32'(err_o),        32'd0);
    check("max_ready", 32'(byte_ready_o), 32'd1);

    // Randomly gapped stream
    do_reset();
    base = wr_count;
    send_frame(5);
    check_two_words("stall");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte
    do_reset();
    base = wr_count;
    for (int i = 0; i < 10; i++) send_byte(frame[i], 0);
    send_byte(8'h66, 0);
    repeat (3) @(negedge clk_i);
    check("csum_err",  32'(err_o),      32'd1);
    check("csum_done", 32'(done_o),     32'd0);
    check("csum_crst", 32'(core_rst_o), 32'd1);
`endif

    // Reset after the 6th byte, then a complete frame
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
    rst_i = 1'b1;
    #2;
    check("mid_rst_ld",   32'(imem_ld_o),  32'd0);
    check("mid_rst_crst", 32'(core_rst_o), 32'd1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    base = wr_count;
    send_frame(0);
    check_two_words("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
